mix_columns_seq: RTL and testbench



---
 rtl/mix_columns_seq.sv | 124 ++++++++++++
 tb/tb_mix_columns_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES MixColumns stage with final-round bypass
// Transforms COLS_PER_CYCLE columns per clock in place; result held until the consumer takes it.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    input  logic         IN_LAST_ROUND,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] MIX_DATA,
    output logic         BUSY
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Index wraps modulo 4, so a step of 4 is a step of 0 and the last group starts at 0.
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] IDX_LAST = 2'((4 - COLS_PER_CYCLE) % 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [127:0] r_data;
    logic [1:0]   r_idx;
    logic [127:0] w_calc_data;
    logic         w_in_xfer;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        int base;
        base        = 0;
        w_calc_data = r_data;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            base = 127 - 32 * int'(r_idx + 2'(j));
            w_calc_data[base -: 32] = mix_col(r_data[base -: 32]);
        end
    end

    always_comb begin
        w_next_state = r_state;
        IN_READY     = 1'b0;
        case (r_state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_next_state = IN_LAST_ROUND ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_idx == IDX_LAST) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Accepting the next state on the same edge as the output transfer avoids a bubble.
                IN_READY = OUT_READY;
                if (OUT_READY) begin
                    if (!IN_VALID) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = IN_LAST_ROUND ? DONE : CALC;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_in_xfer = IN_VALID && IN_READY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (w_in_xfer) begin
            r_data <= IN_DATA;
            r_idx  <= '0;
        end else if (r_state == CALC) begin
            r_data <= w_calc_data;
            r_idx  <= r_idx + IDX_STEP;
        end
    end

    assign OUT_VALID = (r_state == DONE);
    assign BUSY      = (r_state != IDLE);
    assign MIX_DATA  = r_data;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - scoreboard bench for mix_columns_seq at COLS_PER_CYCLE 1, 2 and 4
module tb_mix_columns_seq;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] B2B_IN   = 128'hd4d4d4d5_c6c6c6c6_01010101_db135345;
    localparam logic [127:0] B2B_OUT  = 128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         in_valid [3];
    logic         in_ready [3];
    logic [127:0] in_data  [3];
    logic         in_last  [3];
    logic         out_valid[3];
    logic         out_ready[3];
    logic [127:0] mix_data [3];
    logic         busy     [3];

    genvar gk;
    generate
        for (gk = 0; gk < 3; gk++) begin : g_dut
            localparam int CPC = (gk == 0) ? 1 : (gk == 1) ? 2 : 4;
            mix_columns_seq #(.COLS_PER_CYCLE(CPC)) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .IN_VALID     (in_valid[gk]),
                .IN_READY     (in_ready[gk]),
                .IN_DATA      (in_data[gk]),
                .IN_LAST_ROUND(in_last[gk]),
                .OUT_VALID    (out_valid[gk]),
                .OUT_READY    (out_ready[gk]),
                .MIX_DATA     (mix_data[gk]),
                .BUSY         (busy[gk])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] d;
        int           acc;
        int           lat;
        bit           chk;
    } exp_t;

    exp_t sb[3][$];
    int errors = 0;
    int checks = 0;

    function automatic int cpc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) == 1) p = p ^ x;
            x = (x[7] == 1'b1) ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit last);
        int m[4][4];
        logic [7:0] a[4];
        logic [7:0] acc;
        logic [127:0] r;
        if (last) return s;
        m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++) acc = acc ^ gmul(a[i], m[row][i]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    bit           pv[3];
    bit           px[3];
    logic [127:0] held[3];

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                pv[k] = 1'b0;
                px[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k]) begin
                    if (!pv[k] || px[k]) begin
                        if (sb[k].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL spurious_out dut%0d: got OUT_VALID=1 expected no result", k);
                        end else begin
                            e = sb[k][0];
                            check($sformatf("mix_data dut%0d", k), mix_data[k], e.d);
                            if (e.chk) check($sformatf("latency dut%0d", k), 128'(cyc - e.acc + 1), 128'(e.lat));
                        end
                        held[k] = mix_data[k];
                    end else begin
                        check($sformatf("hold dut%0d", k), mix_data[k], held[k]);
                    end
                    if (!out_ready[k]) check($sformatf("stall_in_ready dut%0d", k), 128'(in_ready[k]), 128'(0));
                    if (out_ready[k] && sb[k].size() > 0) void'(sb[k].pop_front());
                end
                pv[k] = out_valid[k];
                px[k] = out_valid[k] && out_ready[k];
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input bit last, input logic [127:0] exp,
                        input bit chk, input int lat, output int waited);
        exp_t e;
        bit   done;
        in_valid[k] = 1'b1;
        in_data[k]  = d;
        in_last[k]  = last;
        waited      = 0;
        done        = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready[k]) begin
                e.d   = exp;
                e.acc = cyc + 1;
                e.lat = lat;
                e.chk = chk;
                sb[k].push_back(e);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout dut%0d: got IN_READY=0 for %0d cycles expected accept", k, waited);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((sb[k].size() != 0 || out_valid[k]) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("drain dut%0d pending", k), 128'(sb[k].size()), 128'(0));
    endtask

    bit stream_done;

    initial begin
        int w;
        int n;
        logic [127:0] d;
        bit last;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset out_valid dut%0d", k), 128'(out_valid[k]), 128'(0));
            check($sformatf("reset mix_data dut%0d", k), mix_data[k], 128'(0));
            check($sformatf("reset in_ready dut%0d", k), 128'(in_ready[k]), 128'(1));
            check($sformatf("reset busy dut%0d", k), 128'(busy[k]), 128'(0));
        end
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            send(k, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 1 + 4 / cpc_of(k), w);
            drain(k);
            send(k, FIPS_IN, 1'b1, FIPS_IN, 1'b1, 1, w);
            drain(k);
        end

        out_ready[0] = 1'b0;
        send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 5, w);
        n = 0;
        while (!out_valid[0] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp out_valid", 128'(out_valid[0]), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        check("bp busy", 128'(busy[0]), 128'(1));
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = B2B_IN;
        in_last[0]   = 1'b0;
        #1;
        check("b2b in_ready", 128'(in_ready[0]), 128'(1));
        check("b2b out_valid", 128'(out_valid[0]), 128'(1));
        send(0, B2B_IN, 1'b0, B2B_OUT, 1'b1, 5, w);
        check("b2b accept wait", 128'(w), 128'(0));
        drain(0);

        send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1, 5, w);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_valid", 128'(out_valid[0]), 128'(0));
        check("midreset mix_data", mix_data[0], 128'(0));
        check("midreset busy", 128'(busy[0]), 128'(0));
        check("midreset in_ready", 128'(in_ready[0]), 128'(1));
        for (int k = 0; k < 3; k++) sb[k].delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(0, B2B_IN, 1'b0, B2B_OUT, 1'b1, 5, w);
        drain(0);

        for (int k = 0; k < 3; k++) begin
            stream_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        d    = {$urandom, $urandom, $urandom, $urandom};
                        last = ($urandom_range(0, 3) == 0);
                        send(k, d, last, ref_mix(d, last), 1'b0, 0, w);
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    stream_done = 1'b1;
                end
                begin
                    while (!stream_done) begin
                        @(posedge clk);
                        #1;
                        out_ready[k] = ($urandom_range(0, 1) == 1);
                    end
                    out_ready[k] = 1'b1;
                end
            join
            drain(k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
